// File: rtl/pkt_rx_pkg.sv
// Shared types and constants for the exchange-packet receive parser.
package pkt_rx_pkg;

    localparam logic [7:0] TYPE_BYTE_PASSTHROUGH = 8'h01;
    localparam logic [7:0] TYPE_BYTE_REGISTERS   = 8'h02;
    localparam int         HDR_LEN_PT            = 21;
    localparam int         HDR_LEN_REG           = 5;

    typedef enum logic [1:0] {
        RESERVED_TX         = 2'd0,
        MESSAGE_PASSTHROUGH = 2'd1,
        REGISTERS_UPDATE    = 2'd2
    } packet_transaction_type_e;

    typedef enum logic [1:0] {
        DATA_MX_TYPE     = 2'd0,
        HEARTBEAT        = 2'd1,
        RESERVED_MX_TYPE = 2'd2
    } message_type_e;

    typedef enum logic {
        MODE_NORMAL = 1'b0,
        MODE_ALT    = 1'b1
    } mode_e;

    typedef enum logic [2:0] {
        ERR_NONE          = 3'd0,
        ERR_RESERVED_TYPE = 3'd1,
        ERR_LEN_SHORT     = 3'd2,
        ERR_LEN_LONG      = 3'd3,
        ERR_LEN_MAX       = 3'd4,
        ERR_REG_ALIGN     = 3'd5
    } err_code_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_MSG  = 3'd2,
        ST_REG  = 3'd3,
        ST_DROP = 3'd4
    } state_e;

    // Any message type code above HEARTBEAT collapses to the reserved value.
    function automatic message_type_e decode_msg_type(input logic [7:0] b);
        return (b > 8'd1) ? RESERVED_MX_TYPE : message_type_e'(b[1:0]);
    endfunction

endpackage

// File: rtl/pkt_rx_parser_if.sv
// Byte-stream bundle: link input stream plus the passthrough payload stream.
interface pkt_rx_parser_if;
    // A byte moves on a clock edge where valid && ready; valid and its data hold until then.
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_sop;
    logic       in_eop;
    logic       msg_valid;
    logic       msg_ready;
    logic [7:0] msg_data;
    logic       msg_last;

    modport master (
        output in_valid, in_data, in_sop, in_eop,
        input  in_ready,
        input  msg_valid, msg_data, msg_last,
        output msg_ready
    );

    modport slave (
        input  in_valid, in_data, in_sop, in_eop,
        output in_ready,
        output msg_valid, msg_data, msg_last,
        input  msg_ready
    );
endinterface

// File: rtl/pkt_rx_reg_packer.sv
// Packs register payload bytes big-endian into 32-bit writes with an auto-incrementing address.
module pkt_rx_reg_packer #(
    parameter int REG_AW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [REG_AW-1:0] base_addr_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_i,
    output logic              wr_en_o,
    output logic [REG_AW-1:0] wr_addr_o,
    output logic [31:0]       wr_data_o
);
    logic [1:0]        cnt_q;
    logic [23:0]       sr_q;
    logic [REG_AW-1:0] addr_q;
    logic              wr_en_q;
    logic [REG_AW-1:0] wr_addr_q;
    logic [31:0]       wr_data_q;

    // start_i also clears any partial word left by a truncated packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            sr_q      <= '0;
            addr_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= 1'b0;
            if (start_i) begin
                cnt_q  <= '0;
                addr_q <= base_addr_i;
            end else if (byte_valid_i) begin
                if (cnt_q == 2'd3) begin
                    wr_en_q   <= 1'b1;
                    wr_data_q <= {sr_q, byte_i};
                    wr_addr_q <= addr_q;
                    addr_q    <= addr_q + 1'b1;
                end else begin
                    sr_q <= {sr_q[15:0], byte_i};
                end
                cnt_q <= cnt_q + 2'd1;
            end
        end
    end

    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;
endmodule

// File: rtl/pkt_rx_parser.sv
// Exchange-packet receive parser: header capture, payload passthrough, register writes.
// Optional PKT_RX_STATS_EN adds saturating good/error packet counters.
module pkt_rx_parser
    import pkt_rx_pkg::*;
#(
    parameter int MAX_LEN = 1024,
    parameter int REG_AW  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    pkt_rx_parser_if.slave    bus,
    output logic              hdr_valid,
    output logic [1:0]        hdr_type,
    output logic [23:0]       hdr_seq,
    output logic [7:0]        hdr_chan,
    output logic              hdr_mode,
    output logic [15:0]       hdr_len,
    output logic [1:0]        hdr_msg_type,
    output logic [95:0]       hdr_sym,
    output logic              reg_wr_en,
    output logic [REG_AW-1:0] reg_wr_addr,
    output logic [7:0]        reg_wr_blk,
    output logic [31:0]       reg_wr_data,
    output logic              err_valid,
    output logic [2:0]        err_code,
`ifdef PKT_RX_STATS_EN
    output logic [31:0]       stat_pkt_ok,
    output logic [31:0]       stat_pkt_err,
`endif
    output logic [2:0]        dbg_state
);
    localparam logic [31:0] MaxLenW = 32'(MAX_LEN);

    state_e                   state_q, state_d;
    logic [4:0]               cnt_q, cnt_d;
    logic [15:0]              rem_q, rem_d;
    packet_transaction_type_e type_q, type_d;
    logic [151:0]             hdr_sr_q, hdr_sr_d;

    logic                     hdr_valid_q;
    packet_transaction_type_e hdr_type_q;
    logic [23:0]              hdr_seq_q;
    logic [7:0]               hdr_chan_q;
    mode_e                    hdr_mode_q;
    logic [15:0]              hdr_len_q;
    message_type_e            hdr_msg_type_q;
    logic [95:0]              hdr_sym_q;
    logic [7:0]               reg_blk_q;
    logic                     err_valid_q;
    err_code_e                err_code_q;

    logic        err_set, hdr_set, pk_start, pk_byte, pkt_ok;
    err_code_e   err_code_d;
    logic [159:0] hdr_w;
    logic        is_pt;
    logic [4:0]  hdr_last;
    logic [15:0] len_w;
    logic        unused_mode_bits;

    // hdr_w holds header bytes 1..20 once the final passthrough byte is on the bus.
    assign hdr_w            = {hdr_sr_q, bus.in_data};
    assign is_pt            = (type_q == MESSAGE_PASSTHROUGH);
    assign hdr_last         = is_pt ? 5'(HDR_LEN_PT - 1) : 5'(HDR_LEN_REG - 1);
    assign len_w            = is_pt ? hdr_w[119:104] : hdr_w[15:0];
    assign unused_mode_bits = ^hdr_w[127:121];

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rem_d         = rem_q;
        type_d        = type_q;
        hdr_sr_d      = hdr_sr_q;
        err_set       = 1'b0;
        err_code_d    = ERR_NONE;
        hdr_set       = 1'b0;
        pk_start      = 1'b0;
        pk_byte       = 1'b0;
        pkt_ok        = 1'b0;
        bus.in_ready  = 1'b1;
        bus.msg_valid = 1'b0;
        bus.msg_data  = bus.in_data;
        bus.msg_last  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && bus.in_sop) begin
                    if (bus.in_data == TYPE_BYTE_PASSTHROUGH || bus.in_data == TYPE_BYTE_REGISTERS) begin
                        type_d  = (bus.in_data == TYPE_BYTE_PASSTHROUGH) ? MESSAGE_PASSTHROUGH : REGISTERS_UPDATE;
                        cnt_d   = 5'd1;
                        state_d = ST_HDR;
                    end else begin
                        err_set    = 1'b1;
                        err_code_d = ERR_RESERVED_TYPE;
                        state_d    = bus.in_eop ? ST_IDLE : ST_DROP;
                    end
                end
            end
            ST_HDR: begin
                if (bus.in_valid) begin
                    hdr_sr_d = hdr_w[151:0];
                    cnt_d    = cnt_q + 5'd1;
                    if (cnt_q == hdr_last) begin
                        if ({16'd0, len_w} > MaxLenW) begin
                            err_set    = 1'b1;
                            err_code_d = ERR_LEN_MAX;
                            state_d    = bus.in_eop ? ST_IDLE : ST_DROP;
                        end else if (!is_pt && len_w[1:0] != 2'd0) begin
                            err_set    = 1'b1;
                            err_code_d = ERR_REG_ALIGN;
                            state_d    = bus.in_eop ? ST_IDLE : ST_DROP;
                        end else begin
                            hdr_set = 1'b1;
                            if (len_w == 16'd0) begin
                                if (bus.in_eop) begin
                                    state_d = ST_IDLE;
                                    pkt_ok  = 1'b1;
                                end else begin
                                    err_set    = 1'b1;
                                    err_code_d = ERR_LEN_LONG;
                                    state_d    = ST_DROP;
                                end
                            end else if (bus.in_eop) begin
                                err_set    = 1'b1;
                                err_code_d = ERR_LEN_SHORT;
                                state_d    = ST_IDLE;
                            end else begin
                                rem_d    = len_w;
                                pk_start = !is_pt;
                                state_d  = is_pt ? ST_MSG : ST_REG;
                            end
                        end
                    end else if (bus.in_eop) begin
                        err_set    = 1'b1;
                        err_code_d = ERR_LEN_SHORT;
                        state_d    = ST_IDLE;
                    end
                end
            end
            ST_MSG, ST_REG: begin
                if (state_q == ST_MSG) begin
                    bus.in_ready  = bus.msg_ready;
                    bus.msg_valid = bus.in_valid;
                    bus.msg_last  = (rem_q == 16'd1) || bus.in_eop;
                end
                if (bus.in_valid && (state_q == ST_REG || bus.msg_ready)) begin
                    rem_d = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        if (bus.in_eop) begin
                            state_d = ST_IDLE;
                            pkt_ok  = 1'b1;
                        end else begin
                            err_set    = 1'b1;
                            err_code_d = ERR_LEN_LONG;
                            state_d    = ST_DROP;
                        end
                    end else if (bus.in_eop) begin
                        err_set    = 1'b1;
                        err_code_d = ERR_LEN_SHORT;
                        state_d    = ST_IDLE;
                    end
                    // A byte that raises an error never completes a register write.
                    pk_byte = (state_q == ST_REG) && !err_set;
                end
            end
            ST_DROP: begin
                if (bus.in_valid && bus.in_eop) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            rem_q          <= '0;
            type_q         <= RESERVED_TX;
            hdr_sr_q       <= '0;
            hdr_valid_q    <= 1'b0;
            hdr_type_q     <= RESERVED_TX;
            hdr_seq_q      <= '0;
            hdr_chan_q     <= '0;
            hdr_mode_q     <= MODE_NORMAL;
            hdr_len_q      <= '0;
            hdr_msg_type_q <= DATA_MX_TYPE;
            hdr_sym_q      <= '0;
            reg_blk_q      <= '0;
            err_valid_q    <= 1'b0;
            err_code_q     <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            type_q      <= type_d;
            hdr_sr_q    <= hdr_sr_d;
            hdr_valid_q <= hdr_set;
            err_valid_q <= err_set;
            if (err_set) err_code_q <= err_code_d;
            if (hdr_set) begin
                hdr_type_q <= type_q;
                hdr_len_q  <= len_w;
                if (is_pt) begin
                    hdr_seq_q      <= hdr_w[159:136];
                    hdr_chan_q     <= hdr_w[135:128];
                    hdr_mode_q     <= mode_e'(hdr_w[120]);
                    hdr_msg_type_q <= decode_msg_type(hdr_w[103:96]);
                    hdr_sym_q      <= hdr_w[95:0];
                end else begin
                    hdr_seq_q      <= '0;
                    hdr_chan_q     <= '0;
                    hdr_mode_q     <= MODE_NORMAL;
                    hdr_msg_type_q <= DATA_MX_TYPE;
                    hdr_sym_q      <= '0;
                    reg_blk_q      <= hdr_w[23:16];
                end
            end
        end
    end

    pkt_rx_reg_packer #(.REG_AW(REG_AW)) u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (pk_start),
        .base_addr_i  (REG_AW'(hdr_w[31:24])),
        .byte_valid_i (pk_byte),
        .byte_i       (bus.in_data),
        .wr_en_o      (reg_wr_en),
        .wr_addr_o    (reg_wr_addr),
        .wr_data_o    (reg_wr_data)
    );

`ifdef PKT_RX_STATS_EN
    logic [31:0] stat_ok_q, stat_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ok_q  <= '0;
            stat_err_q <= '0;
        end else begin
            if (pkt_ok && stat_ok_q != '1) stat_ok_q <= stat_ok_q + 32'd1;
            if (err_valid_q && stat_err_q != '1) stat_err_q <= stat_err_q + 32'd1;
        end
    end

    assign stat_pkt_ok  = stat_ok_q;
    assign stat_pkt_err = stat_err_q;
`else
    logic unused_pkt_ok;
    assign unused_pkt_ok = pkt_ok;
`endif

    assign hdr_valid    = hdr_valid_q;
    assign hdr_type     = hdr_type_q;
    assign hdr_seq      = hdr_seq_q;
    assign hdr_chan     = hdr_chan_q;
    assign hdr_mode     = hdr_mode_q;
    assign hdr_len      = hdr_len_q;
    assign hdr_msg_type = hdr_msg_type_q;
    assign hdr_sym      = hdr_sym_q;
    assign reg_wr_blk   = reg_blk_q;
    assign err_valid    = err_valid_q;
    assign err_code     = err_code_q;
    assign dbg_state    = state_q;
endmodule

// File: tb/tb_pkt_rx_parser.sv
// Directed bench for pkt_rx_parser: byte driver, negedge monitor, expected-queue scoreboard.
module tb_pkt_rx_parser;
    import pkt_rx_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        hdr_valid;
    logic [1:0]  hdr_type;
    logic [23:0] hdr_seq;
    logic [7:0]  hdr_chan;
    logic        hdr_mode;
    logic [15:0] hdr_len;
    logic [1:0]  hdr_msg_type;
    logic [95:0] hdr_sym;
    logic        reg_wr_en;
    logic [7:0]  reg_wr_addr;
    logic [7:0]  reg_wr_blk;
    logic [31:0] reg_wr_data;
    logic        err_valid;
    logic [2:0]  err_code;
    logic [2:0]  dbg_state;
`ifdef PKT_RX_STATS_EN
    logic [31:0] stat_pkt_ok;
    logic [31:0] stat_pkt_err;
`endif

    pkt_rx_parser_if bus ();

    pkt_rx_parser #(.MAX_LEN(1024), .REG_AW(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .hdr_valid    (hdr_valid),
        .hdr_type     (hdr_type),
        .hdr_seq      (hdr_seq),
        .hdr_chan     (hdr_chan),
        .hdr_mode     (hdr_mode),
        .hdr_len      (hdr_len),
        .hdr_msg_type (hdr_msg_type),
        .hdr_sym      (hdr_sym),
        .reg_wr_en    (reg_wr_en),
        .reg_wr_addr  (reg_wr_addr),
        .reg_wr_blk   (reg_wr_blk),
        .reg_wr_data  (reg_wr_data),
        .err_valid    (err_valid),
        .err_code     (err_code),
`ifdef PKT_RX_STATS_EN
        .stat_pkt_ok  (stat_pkt_ok),
        .stat_pkt_err (stat_pkt_err),
`endif
        .dbg_state    (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard state
    int n_tests = 0;
    int n_fail  = 0;
    int hdr_cnt = 0;
    logic [8:0]  exp_msg_q[$];
    logic [8:0]  obs_msg_q[$];
    logic [39:0] exp_wr_q[$];
    logic [39:0] obs_wr_q[$];
    logic [2:0]  exp_err_q[$];
    logic [2:0]  obs_err_q[$];
    logic [7:0]  pkt_q[$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: everything sampled mid-cycle.
    always @(negedge clk) begin
        if (hdr_valid) hdr_cnt++;
        if (err_valid) obs_err_q.push_back(err_code);
        if (reg_wr_en) obs_wr_q.push_back({reg_wr_addr, reg_wr_data});
        if (bus.msg_valid && bus.msg_ready) obs_msg_q.push_back({bus.msg_last, bus.msg_data});
    end

    // Driver tasks (called aligned to posedge + 1)
    task automatic send_byte(input logic [7:0] d, input logic sop, input logic eop);
        int waitc = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_sop   = sop;
        bus.in_eop   = eop;
        @(negedge clk);
        while (!bus.in_ready && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        if (!bus.in_ready) check("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_sop   = 1'b0;
        bus.in_eop   = 1'b0;
    endtask

    task automatic send_pkt(input bit eop_last);
        for (int i = 0; i < pkt_q.size(); i++)
            send_byte(pkt_q[i], i == 0, eop_last && (i == pkt_q.size() - 1));
        pkt_q.delete();
    endtask

    task automatic pt_hdr(input logic [15:0] len, input logic [7:0] mt);
        pkt_q.push_back(8'h01);
        pkt_q.push_back(8'h0A); pkt_q.push_back(8'h0B); pkt_q.push_back(8'h0C);
        pkt_q.push_back(8'h05);
        pkt_q.push_back(8'h01);
        pkt_q.push_back(len[15:8]); pkt_q.push_back(len[7:0]);
        pkt_q.push_back(mt);
        for (int i = 0; i < 12; i++) pkt_q.push_back(8'hA0 + 8'(i));
    endtask

    task automatic reg_hdr(input logic [7:0] addr, input logic [7:0] blk, input logic [15:0] len);
        pkt_q.push_back(8'h02);
        pkt_q.push_back(addr);
        pkt_q.push_back(blk);
        pkt_q.push_back(len[15:8]);
        pkt_q.push_back(len[7:0]);
    endtask

    task automatic check_sb(input string tag, input int exp_hdr);
        repeat (4) @(negedge clk);
        check({tag, "_hdr_cnt"}, hdr_cnt, exp_hdr);
        check({tag, "_msg_n"}, obs_msg_q.size(), exp_msg_q.size());
        while (exp_msg_q.size() > 0 && obs_msg_q.size() > 0)
            check({tag, "_msg"}, obs_msg_q.pop_front(), exp_msg_q.pop_front());
        check({tag, "_wr_n"}, obs_wr_q.size(), exp_wr_q.size());
        while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0)
            check({tag, "_wr"}, obs_wr_q.pop_front(), exp_wr_q.pop_front());
        check({tag, "_err_n"}, obs_err_q.size(), exp_err_q.size());
        while (exp_err_q.size() > 0 && obs_err_q.size() > 0)
            check({tag, "_err"}, obs_err_q.pop_front(), exp_err_q.pop_front());
        exp_msg_q.delete(); obs_msg_q.delete();
        exp_wr_q.delete();  obs_wr_q.delete();
        exp_err_q.delete(); obs_err_q.delete();
        hdr_cnt = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int stall_bad;
        logic [2:0] stall_state;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_sop    = 1'b0;
        bus.in_eop    = 1'b0;
        bus.msg_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_hdr_valid", hdr_valid, 0);
        check("rst_err_valid", err_valid, 0);
        check("rst_reg_wr_en", reg_wr_en, 0);
        check("rst_hdr_len", hdr_len, 0);
        check("rst_state", dbg_state, ST_IDLE);
        check("rst_in_ready", bus.in_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Passthrough len=3 heartbeat
        pt_hdr(16'd3, 8'h01);
        pkt_q.push_back(8'h5A); pkt_q.push_back(8'h5B); pkt_q.push_back(8'h5C);
        exp_msg_q = '{9'h05A, 9'h05B, 9'h15C};
        send_pkt(1);
        check_sb("pt3", 1);
        check("pt3_type", hdr_type, MESSAGE_PASSTHROUGH);
        check("pt3_seq", hdr_seq, 24'h0A0B0C);
        check("pt3_chan", hdr_chan, 8'h05);
        check("pt3_mode", hdr_mode, 1);
        check("pt3_len", hdr_len, 16'd3);
        check("pt3_msg_type", hdr_msg_type, HEARTBEAT);
        check("pt3_sym", hdr_sym, 96'hA0A1A2A3A4A5A6A7A8A9AAAB);

        // Register write at FE
        reg_hdr(8'hFE, 8'hB7, 16'd8);
        pkt_q.push_back(8'h11); pkt_q.push_back(8'h22); pkt_q.push_back(8'h33); pkt_q.push_back(8'h44);
        pkt_q.push_back(8'h55); pkt_q.push_back(8'h66); pkt_q.push_back(8'h77); pkt_q.push_back(8'h88);
        exp_wr_q = '{{8'hFE, 32'h11223344}, {8'hFF, 32'h55667788}};
        send_pkt(1);
        check_sb("regfe", 1);
        check("regfe_type", hdr_type, REGISTERS_UPDATE);
        check("regfe_len", hdr_len, 16'd8);
        check("regfe_blk", reg_wr_blk, 8'hB7);

        // Register address wrap
        reg_hdr(8'hFF, 8'h01, 16'd8);
        pkt_q.push_back(8'hDE); pkt_q.push_back(8'hAD); pkt_q.push_back(8'hBE); pkt_q.push_back(8'hEF);
        pkt_q.push_back(8'h01); pkt_q.push_back(8'h02); pkt_q.push_back(8'h03); pkt_q.push_back(8'h04);
        exp_wr_q = '{{8'hFF, 32'hDEADBEEF}, {8'h00, 32'h01020304}};
        send_pkt(1);
        check_sb("regwrap", 1);

        // Reserved type, 10 bytes
        pkt_q.push_back(8'h07);
        for (int i = 1; i < 10; i++) pkt_q.push_back(8'(i));
        exp_err_q = '{3'd1};
        send_pkt(1);
        check_sb("rsvd", 0);

        // Passthrough len=5, eop on 2nd payload byte
        pt_hdr(16'd5, 8'h00);
        pkt_q.push_back(8'h31); pkt_q.push_back(8'h32);
        exp_msg_q = '{9'h031, 9'h132};
        exp_err_q = '{3'd2};
        send_pkt(1);
        check_sb("short", 1);

        // Passthrough len=5 with 7 payload bytes
        pt_hdr(16'd5, 8'h03);
        for (int i = 0; i < 7; i++) pkt_q.push_back(8'h40 + 8'(i));
        exp_msg_q = '{9'h040, 9'h041, 9'h042, 9'h043, 9'h144};
        exp_err_q = '{3'd3};
        send_pkt(1);
        check_sb("long", 1);
        check("long_msg_type", hdr_msg_type, RESERVED_MX_TYPE);

        // Register len not word aligned
        reg_hdr(8'h00, 8'h00, 16'd6);
        pkt_q.push_back(8'hAA); pkt_q.push_back(8'hBB);
        exp_err_q = '{3'd5};
        send_pkt(1);
        check_sb("align", 0);

        // Length over MAX_LEN, eop on final header byte
        pt_hdr(16'h0401, 8'h00);
        exp_err_q = '{3'd4};
        send_pkt(1);
        check_sb("lenmax", 0);

        // Register len=0 ending on final header byte
        reg_hdr(8'h20, 8'h09, 16'd0);
        send_pkt(1);
        check_sb("len0", 1);
        check("len0_len", hdr_len, 16'd0);
        check("len0_blk", reg_wr_blk, 8'h09);

        // msg_ready stall mid-payload
        pt_hdr(16'd6, 8'h00);
        for (int i = 0; i < 6; i++) pkt_q.push_back(8'h60 + 8'(i));
        exp_msg_q = '{9'h060, 9'h061, 9'h062, 9'h063, 9'h064, 9'h165};
        stall_bad   = 0;
        stall_state = 3'd7;
        fork
            send_pkt(1);
            begin
                for (int i = 0; i < 300 && obs_msg_q.size() < 2; i++) @(negedge clk);
                @(posedge clk); #1;
                bus.msg_ready = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    if (i == 0) stall_state = dbg_state;
                    if (bus.in_ready) stall_bad++;
                end
                @(posedge clk); #1;
                bus.msg_ready = 1'b1;
            end
        join
        check("stall_in_ready", stall_bad, 0);
        check("stall_state", stall_state, ST_MSG);
        check_sb("stall", 1);

        // Reset mid-payload, then a clean register packet
        pt_hdr(16'd10, 8'h00);
        pkt_q.push_back(8'h70); pkt_q.push_back(8'h71); pkt_q.push_back(8'h72);
        send_pkt(0);
        rst_n = 1'b0;
        @(negedge clk);
        check("mrst_hdr_valid", hdr_valid, 0);
        check("mrst_hdr_len", hdr_len, 0);
        check("mrst_hdr_seq", hdr_seq, 0);
        check("mrst_err_code", err_code, 0);
        check("mrst_state", dbg_state, ST_IDLE);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        reg_hdr(8'h10, 8'h00, 16'd4);
        pkt_q.push_back(8'hCA); pkt_q.push_back(8'hFE); pkt_q.push_back(8'hBA); pkt_q.push_back(8'hBE);
        exp_msg_q = '{9'h070, 9'h071, 9'h072};
        exp_wr_q  = '{{8'h10, 32'hCAFEBABE}};
        send_pkt(1);
        check_sb("mrst", 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
